peripheral_timer: RTL
=====================

PERIPHERAL_TIMER -- requirements
Module: peripheral_timer

Interface
REQ-001 Parameter BASE, default 32'h4000_0000, base byte address of the register window.
REQ-002 Parameter TCON_W, default 3, implemented width of TCON.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr  input  32  byte address from the MEM-stage ALU result.
REQ-006 wdata  input  32  store data.
REQ-007 MemRd  input  1  load strobe, same cycle as addr.
REQ-008 MemWr  input  1  store strobe, same cycle as addr.
REQ-009 kernel  input  1  PC[31] of the instruction in IF; 1 means kernel mode.
REQ-010 rdata  output  32  load data, combinational.
REQ-011 Interrupt  output  1  interrupt request consumed by the IF/ID control decode.

Function
REQ-012 Register map (offset from BASE): 0x00 TH (reload, RW); 0x04 TL (count, RW); 0x08 TCON (RW); 0x0C SYSTICK (RO).
REQ-013 TCON bit 0 = count enable; bit 1 = interrupt enable; bit 2 = interrupt status; bits 31:3 read 0.
REQ-014 A register is selected only on an exact word-aligned match of addr against BASE+offset; any other address hits nothing.
REQ-015 Read: rdata = selected register when MemRd=1 and addr hits; otherwise rdata = 32'h0. Zero latency, no wait states.
REQ-016 Write: with MemWr=1 and an addr hit, the register updates at the next rising clk edge. SYSTICK and unmapped writes are ignored.
REQ-017 SYSTICK increments by 1 every cycle when out of reset and wraps from 32'hFFFF_FFFF to 0.
REQ-018 Counting when TCON[0]=1 and TL is not being written this cycle:
- TL != 32'hFFFF_FFFF: TL <= TL+1.
- TL == 32'hFFFF_FFFF: overflow; TL <= TH (TH as held before any same-cycle TH write).
REQ-019 On overflow with TCON[1]=1, TCON[2] <= 1. On overflow with TCON[1]=0, TCON[2] is unchanged.
REQ-020 While TCON[0]=0, TL holds and no overflow occurs.
REQ-021 A TL write in the same cycle as an overflow: the written value wins, and that overflow is discarded (TCON[2] is not set by it).
REQ-022 A TCON write in the same cycle as an overflow:
- Bits 1:0 take the written value.
- Bit 2 = (written bit 2) OR (overflow AND written bit 1), so a hardware set is never lost.
REQ-023 Software acknowledges the interrupt by writing TCON with bit 2 = 0. There is no other clear path.
REQ-024 Interrupt = TCON[2] & TCON[1] & ~kernel, combinational. It is held as a level until acknowledged, and is masked (not cleared) while kernel=1.
REQ-025 The counter state machine has three states:
- IDLE (TCON[0]=0): no counting.
- RUN: counting.
- PEND (TCON[2]=1): counting continues.
- Transitions follow REQ-018 to REQ-023.
REQ-026 All arithmetic is 32-bit unsigned with wrap-around. No carry-out is exposed.

Reset
REQ-027 While reset=1, TH, TL, TCON and SYSTICK are 0 immediately, regardless of clk.
REQ-028 During reset, Interrupt=0; rdata follows REQ-015 with all registers reading 0.
REQ-029 Reset asserted mid-count or with an interrupt pending discards all state. No interrupt survives reset.
REQ-030 The first count or SYSTICK increment occurs at the first rising clk edge after reset deasserts.

Verification
REQ-031 Periodic interrupt:
- Stimulus: write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFC, TCON=3, kernel=0.
- Response: TL reaches FFFF_FFFF 3 cycles after the TCON write takes effect; TL reloads FFFF_FFFC and Interrupt=1 on the next edge; overflows repeat every 4 cycles.
REQ-032 Acknowledge race:
- Stimulus: TCON write of 3 lands on the same edge as an overflow.
- Response: TCON reads 7 afterward and Interrupt stays 1. A later write of 3 with no overflow gives TCON=3 and Interrupt=0.
REQ-033 TL write priority:
- Stimulus: write TL=32'h1234 on an overflow edge.
- Response: TL=32'h1235 one cycle later and TCON[2]=0.
REQ-034 Masking:
- Stimulus: TCON[2]=1, TCON[1]=1, toggle kernel 0,1,0.
- Response: Interrupt goes 1,0,1 combinationally; TCON unchanged.
REQ-035 Bus decode:
- Read BASE+0x10 or BASE+0x02 -> rdata=0.
- Write SYSTICK=5 -> SYSTICK keeps incrementing and ignores the write.
- MemRd=0 -> rdata=0.
REQ-036 Asynchronous reset:
- Stimulus: assert reset between clk edges with TCON=7 and TL=9.
- Response: all registers read 0 and Interrupt=0 before the next edge; SYSTICK=1 one edge after deassertion.

Source files
------------

// File: rtl/peripheral_timer.sv
// Memory-mapped 32-bit reload timer with free-running SYSTICK and a level interrupt
// that is masked while the fetching instruction is in kernel mode.
module peripheral_timer #(
    parameter logic [31:0] BASE   = 32'h4000_0000,
    parameter int unsigned TCON_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        kernel,
    output logic [31:0] rdata,
    output logic        Interrupt
);

    localparam logic [31:0] ADDR_TH      = BASE;
    localparam logic [31:0] ADDR_TL      = BASE + 32'h0000_0004;
    localparam logic [31:0] ADDR_TCON    = BASE + 32'h0000_0008;
    localparam logic [31:0] ADDR_SYSTICK = BASE + 32'h0000_000C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         th_q, th_d;
    logic [31:0]         tl_q, tl_d;
    logic [TCON_W-1:0]   tcon_q, tcon_d;
    logic [31:0]         systick_q, systick_d;

    logic hit_th, hit_tl, hit_tcon, hit_systick;
    logic wr_th, wr_tl, wr_tcon;
    logic count_en, ovf;

    always_comb begin
        hit_th      = (addr == ADDR_TH);
        hit_tl      = (addr == ADDR_TL);
        hit_tcon    = (addr == ADDR_TCON);
        hit_systick = (addr == ADDR_SYSTICK);
        wr_th       = MemWr & hit_th;
        wr_tl       = MemWr & hit_tl;
        wr_tcon     = MemWr & hit_tcon;
        // A TL store in the same cycle suppresses counting, and with it any overflow.
        count_en    = (state_q != IDLE) & ~wr_tl;
        ovf         = count_en & (tl_q == '1);
    end

    always_comb begin
        th_d      = wr_th ? wdata : th_q;
        systick_d = systick_q + 32'd1;

        tl_d = tl_q;
        if (wr_tl) begin
            tl_d = wdata;
        end else if (count_en) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end

        tcon_d = '0;
        if (wr_tcon) begin
            tcon_d[0] = wdata[0];
            tcon_d[1] = wdata[1];
            // Hardware set merges with the written status so a racing overflow is never lost.
            tcon_d[2] = wdata[2] | (ovf & wdata[1]);
        end else begin
            tcon_d[0] = tcon_q[0];
            tcon_d[1] = tcon_q[1];
            tcon_d[2] = tcon_q[2] | (ovf & tcon_q[1]);
        end

        state_d = IDLE;
        if (tcon_d[0]) begin
            state_d = tcon_d[2] ? PEND : RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            systick_q <= '0;
        end else begin
            state_q   <= state_d;
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (MemRd) begin
            if (hit_th)           rdata = th_q;
            else if (hit_tl)      rdata = tl_q;
            else if (hit_tcon)    rdata = 32'(tcon_q);
            else if (hit_systick) rdata = systick_q;
        end
    end

    assign Interrupt = tcon_q[2] & tcon_q[1] & ~kernel;

endmodule
